// File: rtl/dcache_nway_ctrl.sv
// N-way set-associative, write-through, no-write-allocate data cache with one-word lines.
// A small miss FSM stalls the memory stage while it talks to memory over a req/ready handshake.
module dcache_nway_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    store_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    flush_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    stall_o,
  output logic                    hit_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_ready_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_e;

  state_e                state_q, state_d;
  logic                  flushPend_q, flushPend_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [RR_W-1:0]       rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WAYS-1:0]       hitVec;
  logic                  anyHit;
  logic [RR_W-1:0]       hitWay;
  logic [DATA_WIDTH-1:0] hitData;
  logic [RR_W-1:0]       victim;
  logic                  victimFound;
  logic [RR_W-1:0]       rrNext;
  logic                  fill;
  logic                  merge;
  logic                  flushNow;

  assign idx        = addr_i[OFF_W +: IDX_W];
  assign tag        = addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign anyHit     = |hitVec;
  assign mem_addr_o = (addr_i >> OFF_W) << OFF_W;
  assign rrNext     = (rr_q[idx] == RR_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

  always_comb begin
    hitVec  = '0;
    hitWay  = '0;
    hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hitVec[w] = 1'b1;
        hitWay    = RR_W'(w);
        hitData   = data_q[w][idx];
      end
    end
  end

  // Empty ways are refilled before any valid line is evicted.
  always_comb begin
    victim      = rr_q[idx];
    victimFound = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victimFound && !valid_q[idx][w]) begin
        victim      = RR_W'(w);
        victimFound = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flushPend_d = flushPend_q;
    stall_o     = 1'b0;
    hit_o       = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    fill        = 1'b0;
    merge       = 1'b0;
    flushNow    = 1'b0;
    case (state_q)
      IDLE: begin
        hit_o = (load_i | store_i) & anyHit;
        if (store_i) begin
          stall_o     = 1'b1;
          merge       = anyHit;
          flushPend_d = flush_i;
          state_d     = WR_THRU;
        end else if (load_i && !anyHit) begin
          stall_o     = 1'b1;
          flushPend_d = flush_i;
          state_d     = RD_MISS;
        end else begin
          rdata_o  = load_i ? hitData : '0;
          flushNow = flush_i;
        end
      end
      RD_MISS: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        flushPend_d = flushPend_q | flush_i;
        if (mem_ready_i) begin
          fill    = 1'b1;
          state_d = DONE;
        end
      end
      WR_THRU: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = wdata_i;
        mem_be_o    = be_i;
        flushPend_d = flushPend_q | flush_i;
        if (mem_ready_i) state_d = DONE;
      end
      DONE: begin
        rdata_o     = rdata_q;
        flushNow    = flushPend_q | flush_i;
        flushPend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet for as long as reset is held.
    if (!rst) begin
      stall_o     = 1'b0;
      hit_o       = 1'b0;
      rdata_o     = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      flushPend_q <= 1'b0;
      rdata_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      flushPend_q <= flushPend_d;
      if (fill) begin
        rdata_q   <= mem_rdata_i;
        rr_q[idx] <= rrNext;
      end
      if (flushNow) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill) begin
        valid_q[idx][victim] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= mem_rdata_i;
    end else if (merge) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) data_q[hitWay][idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Directed bench for dcache_nway_ctrl: a transaction-level cache model predicts each cycle's
// outputs and a single negedge process compares the DUT against those predictions.
module tb_dcache_nway_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_i = 1'b0, store_i = 1'b0, flush_i = 1'b0, mem_ready_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0, mem_rdata_i = '0;
  logic [3:0]    be_i = '0;
  logic [DW-1:0] rdata_o, mem_wdata_o;
  logic          stall_o, hit_o, mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;

  always #5 clk = ~clk;

  dcache_nway_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .flush_i(flush_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .hit_o(hit_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic          chkEn = 1'b0;
  logic          expStall = 1'b0, expHit = 1'b0, expReq = 1'b0, expWe = 1'b0, chkRdata = 1'b0;
  logic [AW-1:0] expAddr = '0;
  logic [DW-1:0] expWdata = '0, expRdata = '0;
  logic [3:0]    expBe = '0;

  bit            mValid [WAYS][SETS];
  logic [AW-1:0] mTag   [WAYS][SETS];
  logic [DW-1:0] mData  [WAYS][SETS];
  int            mRr    [SETS];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are judged mid-cycle against whatever the running transaction predicts.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("stall_o", stall_o, expStall);
      checkOutput("hit_o", hit_o, expHit);
      checkOutput("mem_req_o", mem_req_o, expReq);
      checkOutput("mem_we_o", mem_we_o, expWe);
      if (expReq) checkOutput("mem_addr_o", mem_addr_o, expAddr);
      if (expReq && expWe) begin
        checkOutput("mem_wdata_o", mem_wdata_o, expWdata);
        checkOutput("mem_be_o", mem_be_o, expBe);
      end
      if (chkRdata) checkOutput("rdata_o", rdata_o, expRdata);
    end
  end

  function automatic int setOf(input logic [AW-1:0] a);
    return int'((a / 4) % SETS);
  endfunction

  function automatic logic [AW-1:0] tagOf(input logic [AW-1:0] a);
    return a / (4 * SETS);
  endfunction

  function automatic bit modelLookup(input logic [AW-1:0] a, output int way);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (mValid[w][setOf(a)] && mTag[w][setOf(a)] == tagOf(a)) way = w;
    return (way >= 0);
  endfunction

  task automatic modelClear(input bit alsoRr);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mValid[w][s] = 1'b0;
      if (alsoRr) mRr[s] = 0;
    end
  endtask

  task automatic modelFill(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s, v;
    s = setOf(a);
    v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mValid[w][s]) v = w;
    if (v < 0) v = mRr[s];
    mValid[v][s] = 1'b1;
    mTag[v][s]   = tagOf(a);
    mData[v][s]  = d;
    mRr[s]       = (mRr[s] + 1) % WAYS;
  endtask

  task automatic setIdle();
    load_i = 1'b0; store_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
    expStall = 1'b0; expHit = 1'b0; expReq = 1'b0; expWe = 1'b0; chkRdata = 1'b0;
  endtask

  // One pipeline request from presentation to release; called just after a rising edge.
  task automatic applyStimulus(input bit doLoad, input bit doStore, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [3:0] be, input int lat,
                               input logic [DW-1:0] memData, input int flushAt,
                               output bit wasHit, output logic [DW-1:0] loadData);
    int way, s;
    bit hit, pend;
    hit = modelLookup(a, way);
    s = setOf(a);
    wasHit = hit;
    loadData = '0;
    pend = 1'b0;
    load_i = doLoad; store_i = doStore; addr_i = a; wdata_i = wd; be_i = be;
    flush_i = (flushAt == 0);
    expHit = hit; expReq = 1'b0; expWe = 1'b0;
    if (!doStore && hit) begin
      expStall = 1'b0; chkRdata = 1'b1; expRdata = mData[way][s]; loadData = mData[way][s];
      @(posedge clk); #1;
      if (flushAt == 0) modelClear(1'b0);
      setIdle();
      return;
    end
    expStall = 1'b1; chkRdata = 1'b0;
    @(posedge clk); #1;
    if (doStore && hit)
      for (int b = 0; b < 4; b++) if (be[b]) mData[way][s][8*b +: 8] = wd[8*b +: 8];
    if (flushAt == 0) pend = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      flush_i = (flushAt == k); mem_ready_i = (k == lat); mem_rdata_i = memData;
      expHit = 1'b0; expStall = 1'b1; expReq = 1'b1; expWe = doStore;
      expAddr = a & ~32'h3; expWdata = wd; expBe = be;
      @(posedge clk); #1;
      if (flushAt == k) pend = 1'b1;
    end
    if (!doStore) begin
      modelFill(a, memData);
      loadData = memData;
    end
    flush_i = 1'b0; mem_ready_i = 1'b0;
    expStall = 1'b0; expReq = 1'b0; expWe = 1'b0; expHit = 1'b0;
    chkRdata = !doStore; expRdata = memData;
    @(posedge clk); #1;
    if (pend) modelClear(1'b0);
    setIdle();
  endtask

  task automatic flushIdle();
    setIdle();
    flush_i = 1'b1;
    @(posedge clk); #1;
    modelClear(1'b0);
    setIdle();
  endtask

  // Store that is cut off by reset while its memory write is outstanding.
  task automatic resetMidStore(input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int way;
    expHit = modelLookup(a, way);
    store_i = 1'b1; load_i = 1'b0; addr_i = a; wdata_i = wd; be_i = 4'hF;
    expStall = 1'b1; expReq = 1'b0; expWe = 1'b0; chkRdata = 1'b0;
    @(posedge clk); #1;
    expHit = 1'b0; expReq = 1'b1; expWe = 1'b1; expAddr = a & ~32'h3; expWdata = wd; expBe = 4'hF;
    #2;
    rst = 1'b0;
    expStall = 1'b0; expReq = 1'b0; expWe = 1'b0; chkRdata = 1'b1; expRdata = '0;
    #1;
    checkOutput("T6 mem_req_o dropped", mem_req_o, 1'b0);
    checkOutput("T6 stall_o dropped", stall_o, 1'b0);
    modelClear(1'b1);
    @(posedge clk); @(posedge clk); #1;
    setIdle();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit h;
    logic [DW-1:0] d;
    modelClear(1'b1);
    chkRdata = 1'b1; expRdata = '0;
    chkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    setIdle();
    @(posedge clk); #1;

    // T1: cold miss with three memory wait cycles, then a zero-latency hit
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 3, 32'hDEADBEEF, -1, h, d);
    checkOutput("T1 cold load misses", h, 1'b0);
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T1 reload hits", h, 1'b1);
    checkOutput("T1 reload data", d, 32'hDEADBEEF);

    // T2: store hit merges one byte and writes through
    applyStimulus(0, 1, 32'h100, 32'h000000AA, 4'b0001, 1, '0, -1, h, d);
    checkOutput("T2 store hits", h, 1'b1);
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T2 merged data", d, 32'hDEADBEAA);

    // T3: store miss leaves the cache untouched
    applyStimulus(0, 1, 32'h2000, 32'h11223344, 4'hF, 2, '0, -1, h, d);
    checkOutput("T3 store misses", h, 1'b0);
    applyStimulus(1, 0, 32'h2000, '0, 4'h0, 1, 32'h12345678, -1, h, d);
    checkOutput("T3 load after store misses", h, 1'b0);
    applyStimulus(1, 1, 32'h2002, 32'hCAFE0000, 4'b1100, 1, '0, -1, h, d);
    checkOutput("T3 load+store hits", h, 1'b1);
    applyStimulus(1, 0, 32'h2000, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T3 load+store merged", d, 32'hCAFE5678);
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T3 other way intact", d, 32'hDEADBEAA);

    // T4: three lines into one set of two ways
    flushIdle();
    applyStimulus(1, 0, 32'h000, '0, 4'h0, 1, 32'h000000A0, -1, h, d);
    checkOutput("T4 line0 misses", h, 1'b0);
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 2, 32'h000000A1, -1, h, d);
    checkOutput("T4 flushed line misses", h, 1'b0);
    applyStimulus(1, 0, 32'h200, '0, 4'h0, 1, 32'h000000A2, -1, h, d);
    applyStimulus(1, 0, 32'h100, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T4 0x100 survives", h, 1'b1);
    checkOutput("T4 0x100 data", d, 32'h000000A1);
    applyStimulus(1, 0, 32'h000, '0, 4'h0, 1, 32'h000000B0, -1, h, d);
    checkOutput("T4 0x000 evicted", h, 1'b0);

    // T5: flush during a refill is deferred until the load completes
    applyStimulus(1, 0, 32'h300, '0, 4'h0, 3, 32'h55AA55AA, 2, h, d);
    applyStimulus(1, 0, 32'h200, '0, 4'h0, 1, 32'h000000C2, -1, h, d);
    checkOutput("T5 0x200 invalid after flush", h, 1'b0);
    applyStimulus(1, 0, 32'h300, '0, 4'h0, 1, 32'h000000C3, -1, h, d);
    checkOutput("T5 filled line invalid", h, 1'b0);

    // T6: reset in the middle of a write-through
    resetMidStore(32'h200, 32'h77777777);
    applyStimulus(1, 0, 32'h200, '0, 4'h0, 1, 32'h000000D2, -1, h, d);
    checkOutput("T6 0x200 misses", h, 1'b0);
    applyStimulus(1, 0, 32'h300, '0, 4'h0, 2, 32'h000000D3, -1, h, d);
    checkOutput("T6 0x300 misses", h, 1'b0);
    applyStimulus(1, 0, 32'h200, '0, 4'h0, 1, '0, -1, h, d);
    checkOutput("T6 refilled hit data", d, 32'h000000D2);

    @(posedge clk); #1;
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
